// File: rtl/freq_pkg.sv
// Shared types and defaults for the frequency-meter gate sequencer.
// The run-control option in freq_gate_ctrl is enabled by defining FREQ_GATE_RUN_CTRL_EN.
package freq_pkg;

    localparam int DEF_GATE_CYCLES   = 1000;
    localparam int DEF_CLR_CYCLES    = 2;
    localparam int DEF_SETTLE_CYCLES = 4;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        CLEAR  = 3'd1,
        GATE   = 3'd2,
        SETTLE = 3'd3,
        LATCH  = 3'd4
    } freq_state_e;

    typedef struct packed {
        logic [3:0] th;
        logic [3:0] hun;
        logic [3:0] ten;
        logic [3:0] one;
    } bcd4_t;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/freq_digit_latch.sv
// 16-bit load-enabled result register with asynchronous active-low clear.
// Holds the four BCD digits shown on the display between measurements.
module freq_digit_latch
    import freq_pkg::*;
(
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_load,
    input  logic [15:0] i_d,
    output logic [15:0] o_q
);

    bcd4_t r_q;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_q <= '0;
        end else if (i_load) begin
            r_q <= bcd4_t'(i_d);
        end
    end

    assign o_q = r_q;

endmodule

// File: rtl/freq_gate_ctrl.sv
// Gate/clear sequencer for the 4-digit BCD pulse counter with result capture.
// Define FREQ_GATE_RUN_CTRL_EN to add the run input and an IDLE resting state.
module freq_gate_ctrl
    import freq_pkg::*;
#(
    parameter int GATE_CYCLES   = DEF_GATE_CYCLES,
    parameter int CLR_CYCLES    = DEF_CLR_CYCLES,
    parameter int SETTLE_CYCLES = DEF_SETTLE_CYCLES
) (
    input  logic       clk,
    input  logic       reset,
`ifdef FREQ_GATE_RUN_CTRL_EN
    input  logic       run,
`endif
    input  logic [3:0] deci_th,
    input  logic [3:0] deci_hun,
    input  logic [3:0] deci_ten,
    input  logic [3:0] deci,
    output logic       cnt_enable,
    output logic       cnt_reset,
    output logic [3:0] q_th,
    output logic [3:0] q_hun,
    output logic [3:0] q_ten,
    output logic [3:0] q_one,
    output logic       valid
);

    localparam int CW = $clog2(max3(GATE_CYCLES, CLR_CYCLES, SETTLE_CYCLES) + 1);
    localparam logic [CW-1:0] CLR_LAST    = CW'(CLR_CYCLES - 1);
    localparam logic [CW-1:0] GATE_LAST   = CW'(GATE_CYCLES - 1);
    localparam logic [CW-1:0] SETTLE_LAST = CW'(SETTLE_CYCLES - 1);

`ifdef FREQ_GATE_RUN_CTRL_EN
    localparam freq_state_e RESET_STATE = IDLE;
    logic w_run;
    assign w_run = run;
`else
    localparam freq_state_e RESET_STATE = CLEAR;
    logic w_run;
    assign w_run = 1'b1;
`endif

    freq_state_e   r_state;
    logic [CW-1:0] r_cnt;
    logic          r_cnt_enable;
    logic          r_cnt_reset;
    logic          r_valid;

    logic          w_load;
    logic [15:0]   w_digits;
    bcd4_t         w_q;

    // Outputs are registered alongside the state so they line up with it exactly.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state      <= RESET_STATE;
            r_cnt        <= '0;
            r_cnt_enable <= 1'b0;
            r_cnt_reset  <= 1'b0;
            r_valid      <= 1'b0;
        end else begin
            r_cnt   <= r_cnt + CW'(1);
            r_valid <= 1'b0;
            case (r_state)
                IDLE: begin
                    r_cnt <= '0;
                    if (w_run) begin
                        r_state <= CLEAR;
                    end
                end
                CLEAR: begin
                    if (r_cnt == CLR_LAST) begin
                        r_state      <= GATE;
                        r_cnt        <= '0;
                        r_cnt_reset  <= 1'b1;
                        r_cnt_enable <= 1'b1;
                    end
                end
                GATE: begin
                    if (r_cnt == GATE_LAST) begin
                        r_state      <= SETTLE;
                        r_cnt        <= '0;
                        r_cnt_enable <= 1'b0;
                    end
                end
                SETTLE: begin
                    if (r_cnt == SETTLE_LAST) begin
                        r_state <= LATCH;
                        r_cnt   <= '0;
                        r_valid <= 1'b1;
                    end
                end
                LATCH: begin
                    r_cnt       <= '0;
                    r_cnt_reset <= 1'b0;
                    r_state     <= w_run ? CLEAR : IDLE;
                end
                default: begin
                    r_state      <= RESET_STATE;
                    r_cnt        <= '0;
                    r_cnt_enable <= 1'b0;
                    r_cnt_reset  <= 1'b0;
                end
            endcase
        end
    end

    // Capture on the edge that enters LATCH so q_* and valid appear together.
    assign w_load   = (r_state == SETTLE) && (r_cnt == SETTLE_LAST);
    assign w_digits = {deci_th, deci_hun, deci_ten, deci};

    logic [15:0] w_q_raw;

    freq_digit_latch u_digit_latch (
        .i_clk   (clk),
        .i_rst_n (reset),
        .i_load  (w_load),
        .i_d     (w_digits),
        .o_q     (w_q_raw)
    );

    assign w_q        = bcd4_t'(w_q_raw);
    assign q_th       = w_q.th;
    assign q_hun      = w_q.hun;
    assign q_ten      = w_q.ten;
    assign q_one      = w_q.one;
    assign cnt_enable = r_cnt_enable;
    assign cnt_reset  = r_cnt_reset;
    assign valid      = r_valid;

endmodule

// File: tb/tb_freq_gate_ctrl.sv
// Scoreboard bench for freq_gate_ctrl: random digits, timeline model from the period arithmetic.
// Also covers the FREQ_GATE_RUN_CTRL_EN build when that macro is defined.
module tb_freq_gate_ctrl;

    localparam int GATE   = 10;
    localparam int CLR    = 2;
    localparam int SETTLE = 3;
    localparam int PERIOD = CLR + GATE + SETTLE + 1;
`ifdef FREQ_GATE_RUN_CTRL_EN
    localparam int RUN_START = 6;
`else
    localparam int RUN_START = 0;
`endif
    localparam int SEG_B_CYCLES = 5 * PERIOD + RUN_START + 10;

    logic       clk = 1'b0;
    logic       reset;
    logic       run;
    logic [3:0] d_th, d_hun, d_ten, d_one;
    logic       cnt_enable, cnt_reset, valid;
    logic [3:0] q_th, q_hun, q_ten, q_one;

    int          cyc;
    int          seg;
    int          stop_per;
    logic [15:0] hold_val;
    logic [15:0] exp_q[$];
    logic [15:0] held;
    int          n_vec = 0;
    int          n_err = 0;

    always #5 clk = ~clk;

    freq_gate_ctrl #(
        .GATE_CYCLES   (GATE),
        .CLR_CYCLES    (CLR),
        .SETTLE_CYCLES (SETTLE)
    ) dut (
        .clk        (clk),
        .reset      (reset),
`ifdef FREQ_GATE_RUN_CTRL_EN
        .run        (run),
`endif
        .deci_th    (d_th),
        .deci_hun   (d_hun),
        .deci_ten   (d_ten),
        .deci       (d_one),
        .cnt_enable (cnt_enable),
        .cnt_reset  (cnt_reset),
        .q_th       (q_th),
        .q_hun      (q_hun),
        .q_ten      (q_ten),
        .q_one      (q_one),
        .valid      (valid)
    );

    // Position inside the measurement sequence; -1 means the block should be idle.
    function automatic int rel_period(input int c);
        int rel;
        rel = c - RUN_START;
        if (rel < 0) return -1;
        return rel / PERIOD;
    endfunction

    function automatic int rel_phase(input int c);
        int rel;
        rel = c - RUN_START;
        if (rel < 0) return -1;
        if (rel / PERIOD > stop_per) return -1;
        return rel % PERIOD;
    endfunction

    task automatic set_digits(input logic [15:0] v);
        {d_th, d_hun, d_ten, d_one} = v;
    endtask

    task automatic drive_cycle();
        int          ph;
        int          p;
        logic [15:0] v;
        ph = rel_phase(cyc);
        p  = rel_period(cyc);
        v  = 16'($urandom);
        if (seg == 0 && p == 1) v = 16'h9999;
        if (ph >= CLR + GATE) begin
            if (ph == CLR + GATE) begin
                if (seg == 0 && p == 0)      hold_val = 16'h1234;
                else if (seg == 0 && p == 1) hold_val = 16'h9999;
                else if (seg == 0 && p == 2) hold_val = 16'hAF09;
                else                         hold_val = v;
                exp_q.push_back(hold_val);
            end
            set_digits(hold_val);
        end else begin
            set_digits(v);
        end
        if (cyc == RUN_START - 1) run = 1'b1;
        if (p == stop_per && ph == CLR + 4) run = 1'b0;
    endtask

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s cyc=%0d got=%h expected=%h", name, cyc, act, exp);
        end
    endtask

    // Monitor: timeline against the period model, q_* against the scoreboard queue.
    always @(negedge clk) begin
        int          ph;
        logic [15:0] q_now;
        logic [15:0] e;
        q_now = {q_th, q_hun, q_ten, q_one};
        if (!reset) begin
            held = 16'h0;
            check("rst_cnt_enable", {15'b0, cnt_enable}, 16'h0);
            check("rst_cnt_reset", {15'b0, cnt_reset}, 16'h0);
            check("rst_valid", {15'b0, valid}, 16'h0);
            check("rst_q", q_now, 16'h0);
        end else begin
            ph = rel_phase(cyc);
            check("cnt_reset", {15'b0, cnt_reset}, {15'b0, ph >= CLR});
            check("cnt_enable", {15'b0, cnt_enable}, {15'b0, (ph >= CLR) && (ph < CLR + GATE)});
            check("valid", {15'b0, valid}, {15'b0, ph == PERIOD - 1});
            if (valid) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_valid", 16'h1, 16'h0);
                end else begin
                    e = exp_q.pop_front();
                    check("latched_q", q_now, e);
                    held = e;
                    $display("latch cyc=%0d q=%h expected=%h", cyc, q_now, e);
                end
            end else begin
                check("q_hold", q_now, held);
            end
        end
    end

    initial begin
        reset    = 1'b0;
        run      = 1'b0;
        cyc      = 0;
        seg      = 0;
        stop_per = 1000;
        hold_val = 16'h0;
        held     = 16'h0;
        set_digits(16'h0);
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b1;
        drive_cycle();
        // Segment A: continuous measurement, aborted by reset in GATE cycle 6 of period 3.
        while (1) begin
            @(posedge clk);
            #1;
            cyc++;
            if (rel_period(cyc) == 3 && rel_phase(cyc) == CLR + 6) break;
            drive_cycle();
        end
        reset = 1'b0;
        run   = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        cyc = 0;
        seg = 1;
`ifdef FREQ_GATE_RUN_CTRL_EN
        stop_per = 2;
`endif
        reset = 1'b1;
        drive_cycle();
        for (int i = 0; i < SEG_B_CYCLES; i++) begin
            @(posedge clk);
            #1;
            cyc++;
            drive_cycle();
        end
        @(negedge clk);
        #1;
        n_vec++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL pending_results got=%0d expected=0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
